// File: rtl/fib_index_finder.sv
// fib_index_finder: locates the smallest index n with F(n) == target for the
// extended Fibonacci sequence F(0)=F(1)=1, F(k)=(k-2)*F(k-1)+F(k-2).
// One index is examined per clock. The search stops early once the sequence
// passes the target, because the sequence never decreases.
//
// Handshake: start is a single-cycle request. It is accepted only when busy=0
// (IDLE or DONE), and target is captured on that same edge. busy stays high
// for the whole search. done rises together with valid found/n_out and holds
// them until the next accepted start; done drops on that start edge.
module fib_index_finder #(
  parameter int W  = 121,
  parameter int NW = 5
) (
  input  logic          clk,
  input  logic          reset,      // asynchronous, active-low
  input  logic          start,
  input  logic [W-1:0]  target,
  output logic          busy,
  output logic          done,
  output logic          found,
  output logic [NW-1:0] n_out,
  output logic [1:0]    dbg_state   // controller state, for observation only
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEARCH = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  localparam logic [NW-1:0] K_LAST = '1;

  state_t        state_q, state_d;
  logic [W-1:0]  t_q, t_d;
  logic [W-1:0]  prev_q, prev_d;
  logic [W-1:0]  cur_q, cur_d;
  logic [NW-1:0] k_q, k_d;
  logic          ovf_q, ovf_d;
  logic          found_q, found_d;
  logic [NW-1:0] n_q, n_d;

  logic [NW-1:0]   km1;
  logic [W+NW-1:0] next_w;

  // Next sequence term (k-1)*F(k) + F(k-1), kept wide so overflow is visible.
  always_comb begin
    km1    = k_q - NW'(1);
    next_w = ({{NW{1'b0}}, cur_q} * {{W{1'b0}}, km1}) + {{NW{1'b0}}, prev_q};
  end

  // Controller next state and datapath updates.
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    prev_d  = prev_q;
    cur_d   = cur_q;
    k_d     = k_q;
    ovf_d   = ovf_q;
    found_d = found_q;
    n_d     = n_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_SEARCH;
          t_d     = target;
          k_d     = NW'(1);
          prev_d  = W'(1);
          cur_d   = W'(1);
          ovf_d   = 1'b0;
          found_d = 1'b0;
          n_d     = '0;
        end
      end
      S_SEARCH: begin
        // A truncated value after overflow is meaningless, so overflow is
        // checked before any comparison against the target.
        if (ovf_q || (cur_q > t_q)) begin
          state_d = S_DONE;
          found_d = 1'b0;
          n_d     = '0;
        end else if (cur_q == t_q) begin
          state_d = S_DONE;
          found_d = 1'b1;
          // F(0)=F(1)=F(2)=1: the smallest matching index for 1 is 0.
          n_d     = (k_q == NW'(1)) ? '0 : k_q;
        end else if (k_q == K_LAST) begin
          state_d = S_DONE;
          found_d = 1'b0;
          n_d     = '0;
        end else begin
          prev_d = cur_q;
          cur_d  = next_w[W-1:0];
          k_d    = k_q + NW'(1);
          if (next_w[W+NW-1:W] != '0) ovf_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any search in progress.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      t_q     <= '0;
      prev_q  <= '0;
      cur_q   <= '0;
      k_q     <= '0;
      ovf_q   <= 1'b0;
      found_q <= 1'b0;
      n_q     <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      prev_q  <= prev_d;
      cur_q   <= cur_d;
      k_q     <= k_d;
      ovf_q   <= ovf_d;
      found_q <= found_d;
      n_q     <= n_d;
    end
  end

  // Outputs are decoded straight from registers.
  always_comb begin
    busy      = (state_q == S_SEARCH);
    done      = (state_q == S_DONE);
    found     = found_q;
    n_out     = n_q;
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_fib_index_finder.sv
// Directed bench for fib_index_finder: a vector table of targets with
// hand-computed index, found flag and latency, plus sequences for reset,
// busy protection, restart from DONE, mid-search reset and overflow.
module tb_fib_index_finder;

  localparam int W  = 121;
  localparam int NW = 5;
  localparam int SW = 8;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic          start;
  logic [W-1:0]  target;
  logic          busy, done, found;
  logic [NW-1:0] n_out;
  logic [1:0]    dbg_state;

  logic          s_start;
  logic [SW-1:0] s_target;
  logic          s_busy, s_done, s_found;
  logic [NW-1:0] s_n_out;
  logic [1:0]    s_dbg_state;

  fib_index_finder #(.W(W), .NW(NW)) u_dut (
    .clk(clk), .reset(reset), .start(start), .target(target),
    .busy(busy), .done(done), .found(found), .n_out(n_out),
    .dbg_state(dbg_state)
  );

  fib_index_finder #(.W(SW), .NW(NW)) u_small (
    .clk(clk), .reset(reset), .start(s_start), .target(s_target),
    .busy(s_busy), .done(s_done), .found(s_found), .n_out(s_n_out),
    .dbg_state(s_dbg_state)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [NW-1:0] exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Pulse start for one edge; returns #1 after the accepting edge.
  task automatic launch(input logic [W-1:0] t);
    @(negedge clk);
    start  = 1'b1;
    target = t;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Count edges until done, starting from c0 edges already elapsed.
  task automatic wait_done(input int c0, output int cyc, output int busy_cyc);
    cyc      = c0;
    busy_cyc = 0;
    while (!done && cyc < 64) begin
      if (busy) busy_cyc++;
      @(posedge clk);
      #1;
      cyc++;
    end
    check("timeout", int'(cyc >= 64), 0);
  endtask

  typedef struct {
    logic [W-1:0]  target;
    logic          exp_found;
    logic [NW-1:0] exp_n;
    int            exp_cyc;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int cyc, bc;
    logic [NW-1:0] en;

    vecs[0] = '{target: W'(382),    exp_found: 1'b1, exp_n: 5'd7,  exp_cyc: 7};
    vecs[1] = '{target: W'(1),      exp_found: 1'b1, exp_n: 5'd0,  exp_cyc: 1};
    vecs[2] = '{target: W'(0),      exp_found: 1'b0, exp_n: 5'd0,  exp_cyc: 1};
    vecs[3] = '{target: W'(137861), exp_found: 1'b1, exp_n: 5'd10, exp_cyc: 10};
    vecs[4] = '{target: W'(2),      exp_found: 1'b1, exp_n: 5'd3,  exp_cyc: 3};
    vecs[5] = '{target: W'(100),    exp_found: 1'b0, exp_n: 5'd0,  exp_cyc: 7};
    vecs[6] = '{target: W'(17),     exp_found: 1'b1, exp_n: 5'd5,  exp_cyc: 5};
    vecs[7] = '{target: W'(3),      exp_found: 1'b0, exp_n: 5'd0,  exp_cyc: 4};
    vecs[8] = '{target: W'(2365),   exp_found: 1'b1, exp_n: 5'd8,  exp_cyc: 8};
    // Largest target: no term exceeds it, so the search runs to k = 31.
    vecs[9] = '{target: {W{1'b1}},  exp_found: 1'b0, exp_n: 5'd0,  exp_cyc: 31};

    reset    = 1'b1;
    start    = 1'b0;
    target   = '0;
    s_start  = 1'b0;
    s_target = '0;
    #1;
    reset  = 1'b0;
    start  = 1'b1;
    target = W'(382);
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",  int'(busy),  0);
    check("rst_done",  int'(done),  0);
    check("rst_found", int'(found), 0);
    check("rst_n",     int'(n_out), 0);
    @(negedge clk);
    start = 1'b0;
    reset = 1'b1;

    // Table-driven searches.
    for (int i = 0; i < 10; i++) begin
      launch(vecs[i].target);
      check($sformatf("v%0d_done_drop", i), int'(done), 0);
      exp_q.push_back(vecs[i].exp_n);
      wait_done(0, cyc, bc);
      en = exp_q.pop_front();
      check($sformatf("v%0d_cycles", i), cyc, vecs[i].exp_cyc);
      check($sformatf("v%0d_busy_cycles", i), bc, vecs[i].exp_cyc);
      check($sformatf("v%0d_found", i), int'(found), int'(vecs[i].exp_found));
      check($sformatf("v%0d_n", i), int'(n_out), int'(en));
    end

    // Busy protection: a second start during the search is ignored.
    launch(W'(16937));
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    start  = 1'b1;
    target = W'(5);
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(3, cyc, bc);
    check("prot_cycles", cyc, 9);
    check("prot_found",  int'(found), 1);
    check("prot_n",      int'(n_out), 9);

    // Restart directly from DONE.
    launch(W'(5));
    check("restart_done_drop", int'(done), 0);
    check("restart_busy",      int'(busy), 1);
    wait_done(0, cyc, bc);
    check("restart_cycles", cyc, 4);
    check("restart_found",  int'(found), 1);
    check("restart_n",      int'(n_out), 4);

    // Reset in the middle of a search clears everything at once.
    launch(W'(137861));
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst_busy",  int'(busy),  0);
    check("midrst_done",  int'(done),  0);
    check("midrst_found", int'(found), 0);
    check("midrst_n",     int'(n_out), 0);
    @(negedge clk);
    reset = 1'b1;
    launch(W'(137861));
    wait_done(0, cyc, bc);
    check("after_rst_cycles", cyc, 10);
    check("after_rst_found",  int'(found), 1);
    check("after_rst_n",      int'(n_out), 10);

    // Narrow instance: 382 does not fit in 8 bits, so the search must stop
    // at k=7 on overflow rather than compare the truncated value 126.
    @(negedge clk);
    s_start  = 1'b1;
    s_target = SW'(200);
    @(posedge clk);
    #1;
    s_start = 1'b0;
    cyc = 0;
    while (!s_done && cyc < 64) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("ovf_cycles", cyc, 7);
    check("ovf_done",   int'(s_done), 1);
    check("ovf_found",  int'(s_found), 0);
    check("ovf_n",      int'(s_n_out), 0);

    // ---------------- final report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fib_index_finder.md
Name: fib_index_finder

Overview:
- Inverse of the extended-Fibonacci evaluator: given a target value X, finds the smallest index n with F(n) == X, or reports not-found.
- Recurrence: F(0)=1, F(1)=1, F(k)=(k-2)*F(k-1)+F(k-2) for k>=2. Sequence: 1,1,1,2,5,17,73,382,2365,16937,137861,...
- Iterative datapath (two value registers, index counter, small-constant multiplier, adder, comparator) under a 3-state controller.
- Sits beside the evaluator so software or test logic can round-trip n -> F(n) -> n.

Parameters:
- W, 121, value width of target and sequence registers.
- NW, 5, index width; search covers k = 1 .. 2^NW-1.

Ports:
- clk  input  1  clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle request; sampled only in IDLE or DONE.
- target  input  W  value to locate; captured on the accepted start edge.
- busy  output  1  high while searching.
- done  output  1  high in DONE; results valid while high.
- found  output  1  1 = index located, 0 = X is not a sequence value within range.
- n_out  output  NW  smallest matching index; 0 when found=0.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; busy=0, done=0, found=0, n_out=0; internal registers cleared. Reset mid-search aborts with no result.
- States:
  - IDLE: start=1 -> SEARCH. Capture T=target and load k=1, prev=F(0)=1, cur=F(1)=1.
  - SEARCH: one index per cycle; busy=1.
  - DONE: done=1; results held. start=1 -> SEARCH (same load as IDLE) and done drops on that edge.
- SEARCH, evaluated each cycle on k, cur, prev; registered outcome at the edge:
  - cur == T: -> DONE, found=1, n_out = (k==1) ? 0 : k. F(0)=F(1)=F(2)=1, so the smallest index 0 is reported for T=1.
  - cur > T, or the overflow flag is set: -> DONE, found=0, n_out=0. The sequence is non-decreasing, so no later match exists.
  - k == 2^NW-1 and no match: -> DONE, found=0, n_out=0.
  - Otherwise advance: next = (k-1)*cur + prev, computed W+NW bits wide; prev<=cur; cur<=next[W-1:0]; k<=k+1.
  - If next exceeds W bits, set a sticky overflow flag; the next cycle treats it as cur > T.
- Latency: a match at k>=1 asserts done k cycles after the start edge (T=1: 1 cycle). Not-found asserts done at the first k with F(k) > T.
- start while busy=1 is ignored; target is not re-sampled.
- Outputs are registered; there is no combinational path from start or target to any output.
- Multiplier operand (k-1) is at most 2^NW-2. Single-cycle multiply-add; no pipelining.

Test Plan:
- Reset: hold reset=0 with start=1 -> busy=0, done=0, found=0, n_out=0. Release and pulse start with target=382 -> done 7 cycles later, found=1, n_out=7, busy high for exactly 7 cycles.
- Boundaries:
  - target=1 -> done after 1 cycle, found=1, n_out=0.
  - target=0 -> done after 1 cycle, found=0, n_out=0.
- Deep match: target=137861 -> done after 10 cycles, found=1, n_out=10. target=2 -> done after 3 cycles, n_out=3.
- Not found: target=100 (between 73 and 382) -> done at k=7 (7 cycles), found=0, n_out=0.
- Busy protection and restart: start with target=16937, re-pulse start with target=5 at cycle 3 -> ignored; done at 9 cycles with n_out=9. Then in DONE pulse start with target=5 -> done drops, reasserts after 4 cycles with n_out=4.
- Mid-search reset and overflow:
  - Assert reset at cycle 5 of a target=137861 search -> outputs clear immediately; a fresh start gives the correct result.
  - With W=8, target=200 -> overflow detected at k=6 (F(6)=73 fits, F(7)=382 does not); not-found reported with found=0.
